// File: rtl/or_nway_pipe_pkg.sv
// ============================================================================
// Module  : or_nway_pipe_pkg
// Brief   : Elaboration-time helpers for pipelined reduction trees.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package or_nway_pipe_pkg;

  // Smallest r with 2**r >= n.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int num_stages(input int levels, input int every);
    return (levels + every - 1) / every;
  endfunction

  // The final stage may carry fewer than REG_EVERY levels.
  function automatic int stage_lvls(input int levels, input int every, input int s);
    int rem;
    rem = levels - s * every;
    return (rem < every) ? rem : every;
  endfunction

endpackage

`default_nettype wire

// File: rtl/or_tree_stage.sv
// ============================================================================
// Module  : or_tree_stage
// Brief   : Combinational reduction of IN_W bits through LVLS levels of 2-input ORs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module or_tree_stage #(
  parameter int IN_W = 4,
  parameter int LVLS = 2
) (
  input  logic [IN_W-1:0]          in,
  output logic [(IN_W>>LVLS)-1:0]  out
);

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int W = IN_W >> l;
    logic [W-1:0] w_v;
    if (l == 0) begin : g_leaf
      assign w_v = in;
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_or
        assign w_v[j] = g_lvl[l-1].w_v[2*j] | g_lvl[l-1].w_v[2*j+1];
      end
    end
  end

  assign out = g_lvl[LVLS].w_v;

endmodule

`default_nettype wire

// File: rtl/or_nway_pipe.sv
// ============================================================================
// Module  : or_nway_pipe
// Brief   : Pipelined per-channel OR reduction with a sticky accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module or_nway_pipe
  import or_nway_pipe_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int REG_EVERY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      sticky_en,
  input  logic                      clear,
  output logic                      out_valid,
  output logic [CHANNELS-1:0]       out,
  output logic [CHANNELS-1:0]       sticky
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int STAGES = num_stages(LEVELS, REG_EVERY);
  localparam int PAD    = 1 << LEVELS;

  logic [STAGES-1:0]   r_valid;
  logic                w_res_valid;
  logic [CHANNELS-1:0] w_res;
  logic [CHANNELS-1:0] r_sticky;

  if (STAGES == 1) begin : g_vchain_one
    assign w_res_valid = in_valid;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_valid <= '0;
      else       r_valid <= in_valid;
    end
  end else begin : g_vchain
    assign w_res_valid = r_valid[STAGES-2];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) r_valid <= '0;
      else       r_valid <= {r_valid[STAGES-2:0], in_valid};
    end
  end

  assign out_valid = r_valid[STAGES-1];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [PAD-1:0] w_leaf;
    // Zero-extension supplies the padding leaves for non-power-of-two widths.
    assign w_leaf = PAD'(in_data[c*WIDTH +: WIDTH]);

    for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int LV    = stage_lvls(LEVELS, REG_EVERY, s);
      localparam int IN_W  = PAD >> (s * REG_EVERY);
      localparam int OUT_W = IN_W >> LV;

      logic [IN_W-1:0]  w_in;
      logic [OUT_W-1:0] w_out;
      logic [OUT_W-1:0] r_q;

      if (s == 0) begin : g_src_leaf
        assign w_in = w_leaf;
      end else begin : g_src_prev
        assign w_in = g_st[s-1].r_q;
      end

      or_tree_stage #(
        .IN_W (IN_W),
        .LVLS (LV)
      ) u_tree (
        .in  (w_in),
        .out (w_out)
      );

      if (s == STAGES - 1) begin : g_last
        // Gate with valid so out reads 0 whenever out_valid is low.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) r_q <= '0;
          else       r_q <= w_out & {OUT_W{w_res_valid}};
        end
      end else begin : g_mid
        always_ff @(posedge clk or posedge reset) begin
          if (reset) r_q <= '0;
          else       r_q <= w_out;
        end
      end
    end

    assign w_res[c] = g_st[STAGES-1].w_out[0];
    assign out[c]   = g_st[STAGES-1].r_q[0];
  end

  // Clear applies first, so a result arriving with clear still lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sticky <= '0;
    else       r_sticky <= (clear ? '0 : r_sticky) |
                           ((sticky_en && w_res_valid) ? w_res : '0);
  end

  assign sticky = r_sticky;

endmodule

`default_nettype wire

// File: tb/tb_or_nway_pipe.sv
// ============================================================================
// Module  : tb_or_nway_pipe
// Brief   : Directed bench for or_nway_pipe at 16/2/2 and 13/2/1 configurations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_or_nway_pipe;

  typedef struct {
    logic        v;
    logic [15:0] d1;
    logic [15:0] d0;
    logic        ev;
    logic [1:0]  eo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_in_valid, a_sticky_en, a_clear, a_out_valid;
  logic [31:0] a_in_data;
  logic [1:0]  a_out, a_sticky;
  logic        b_in_valid, b_sticky_en, b_clear, b_out_valid;
  logic [25:0] b_in_data;
  logic [1:0]  b_out, b_sticky;

  int errors = 0;
  int checks = 0;

  vec_t ta[25];
  vec_t tvb[17];

  always #5 clk = ~clk;

  or_nway_pipe #(.WIDTH(16), .CHANNELS(2), .REG_EVERY(2)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .sticky_en(a_sticky_en), .clear(a_clear),
    .out_valid(a_out_valid), .out(a_out), .sticky(a_sticky)
  );

  or_nway_pipe #(.WIDTH(13), .CHANNELS(2), .REG_EVERY(1)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .sticky_en(b_sticky_en), .clear(b_clear),
    .out_valid(b_out_valid), .out(b_out), .sticky(b_sticky)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_vec(input int which, input vec_t t);
    if (which == 0) begin
      a_in_valid = t.v;
      a_in_data  = {t.d1, t.d0};
    end else begin
      b_in_valid = t.v;
      b_in_data  = {t.d1[12:0], t.d0[12:0]};
    end
  endtask

  task automatic run_table(input int which, input int n, input int lat);
    vec_t t;
    vec_t idle;
    int   k;
    idle.v = 1'b0; idle.d1 = 16'hFFFF; idle.d0 = 16'hFFFF; idle.ev = 1'b0; idle.eo = 2'b00;
    for (int i = 0; i < n + lat - 1; i++) begin
      if (i < n) t = (which == 0) ? ta[i] : tvb[i];
      else       t = idle;
      drive_vec(which, t);
      @(posedge clk); #1;
      k = i - lat + 1;
      if (k >= 0) begin
        t = (which == 0) ? ta[k] : tvb[k];
        if (which == 0) begin
          chk($sformatf("A_vec%0d_valid", k), a_out_valid, t.ev);
          chk($sformatf("A_vec%0d_out", k), a_out, t.eo);
          chk($sformatf("A_vec%0d_sticky", k), a_sticky, 2'b00);
        end else begin
          chk($sformatf("B_vec%0d_valid", k), b_out_valid, t.ev);
          chk($sformatf("B_vec%0d_out", k), b_out, t.eo);
        end
      end
    end
  endtask

  // Drive DUT A for one cycle, then check its outputs just after the edge.
  task automatic s_a(input string nm, input logic v, input logic [15:0] d1, input logic [15:0] d0,
                     input logic en, input logic clr,
                     input logic ev, input logic [1:0] eo, input logic [1:0] es);
    a_in_valid  = v;
    a_in_data   = {d1, d0};
    a_sticky_en = en;
    a_clear     = clr;
    @(posedge clk); #1;
    chk({nm, "_valid"}, a_out_valid, ev);
    chk({nm, "_out"}, a_out, eo);
    chk({nm, "_sticky"}, a_sticky, es);
  endtask

  initial begin
    // Vector tables
    for (int k = 0; k < 16; k++) begin
      ta[k].v = 1'b1; ta[k].d1 = 16'h0000; ta[k].d0 = 16'h0001 << k; ta[k].ev = 1'b1; ta[k].eo = 2'b01;
    end
    ta[16] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 2'b00};
    ta[17] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 2'b00};
    ta[18] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 2'b00};
    ta[19] = '{1'b1, 16'h0000, 16'h8000, 1'b1, 2'b01};
    ta[20] = '{1'b1, 16'h0000, 16'h0001, 1'b1, 2'b01};
    ta[21] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 2'b00};
    ta[22] = '{1'b1, 16'h0400, 16'h0000, 1'b1, 2'b10};
    ta[23] = '{1'b1, 16'h0002, 16'h0100, 1'b1, 2'b11};
    ta[24] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 2'b11};
    for (int k = 0; k < 13; k++) begin
      tvb[k].v = 1'b1; tvb[k].d1 = 16'h0000; tvb[k].d0 = 16'h0001 << k; tvb[k].ev = 1'b1; tvb[k].eo = 2'b01;
    end
    tvb[13] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 2'b00};
    tvb[14] = '{1'b1, 16'h1000, 16'h0000, 1'b1, 2'b10};
    tvb[15] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 2'b00};
    tvb[16] = '{1'b1, 16'h0001, 16'h1000, 1'b1, 2'b11};

    // Reset held with valid all-ones input
    reset = 1'b1;
    a_in_valid = 1'b1; a_in_data = '1; a_sticky_en = 1'b1; a_clear = 1'b0;
    b_in_valid = 1'b1; b_in_data = '1; b_sticky_en = 1'b1; b_clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_A_valid", a_out_valid, 1'b0);
      chk("rst_A_out", a_out, 2'b00);
      chk("rst_A_sticky", a_sticky, 2'b00);
      chk("rst_B_valid", b_out_valid, 1'b0);
      chk("rst_B_sticky", b_sticky, 2'b00);
    end
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      chk($sformatf("lat_A_valid_e%0d", e), a_out_valid, (e == 2));
      chk($sformatf("lat_A_out_e%0d", e), a_out, (e == 2) ? 2'b11 : 2'b00);
      chk($sformatf("lat_A_sticky_e%0d", e), a_sticky, (e >= 2) ? 2'b11 : 2'b00);
      chk($sformatf("lat_B_valid_e%0d", e), b_out_valid, (e == 4));
      chk($sformatf("lat_B_out_e%0d", e), b_out, (e == 4) ? 2'b11 : 2'b00);
      chk($sformatf("lat_B_sticky_e%0d", e), b_sticky, (e >= 4) ? 2'b11 : 2'b00);
    end
    a_clear = 1'b1; b_clear = 1'b1; a_sticky_en = 1'b0; b_sticky_en = 1'b0;
    @(posedge clk); #1;
    a_clear = 1'b0; b_clear = 1'b0;
    chk("clr_A_sticky", a_sticky, 2'b00);
    chk("clr_B_sticky", b_sticky, 2'b00);

    // Walk, zero word, valid gaps
    run_table(0, 25, 2);
    run_table(1, 17, 4);

    // Sticky accumulate and hold, then clear alone
    s_a("stk0", 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    s_a("stk1", 1'b1, 16'h0400, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00);
    s_a("stk2", 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10);
    s_a("stk3", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10);
    s_a("stk4", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10);
    s_a("stk_clr", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);

    // sticky_en sampled at result arrival, not at launch
    s_a("en0", 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    s_a("en1", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00);
    s_a("en2", 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    s_a("en3", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01);
    s_a("en_clr", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);

    // Clear colliding with an arriving result
    s_a("col0", 1'b1, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    s_a("col1", 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10);
    s_a("col2", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01);
    s_a("col3", 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01);
    s_a("col_clr", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);

    // Mid-stream reset discards in-flight words
    s_a("mid0", 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
    b_in_valid = 1'b1; b_in_data = 26'h1;
    s_a("mid1", 1'b1, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01);
    b_in_valid = 1'b0;
    a_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_A_valid", a_out_valid, 1'b0);
    chk("async_A_out", a_out, 2'b00);
    chk("async_A_sticky", a_sticky, 2'b00);
    chk("async_B_valid", b_out_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_A_valid%0d", i), a_out_valid, 1'b0);
      chk($sformatf("post_rst_A_sticky%0d", i), a_sticky, 2'b00);
      chk($sformatf("post_rst_B_valid%0d", i), b_out_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
